// File: rtl/seq_detector_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial bit-pattern detector.
//   DEF_PAT_LEN  - default pattern length in bits (2..8)
//   DEF_PATTERN  - default target sequence, right-aligned; MSB of the used
//                  slice is the oldest bit, LSB the newest
//   DEF_HIST_W   - default width of the displayed bit history
//   DEF_CNT_W    - default width of the saturating match counter
//   CNT_MAX      - saturation value of the default-width match counter
//   fill_state_e - FILLING while the window is incomplete, FULL once it
//                  holds a whole pattern's worth of bits
//   satFill      - fill increment that stops at the pattern length
// ----------------------------------------------------------------------------
package seq_pkg;

   localparam int DEF_PAT_LEN = 4;
   localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
   localparam int DEF_HIST_W = 8;
   localparam int DEF_CNT_W = 8;
   localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      FILLING = 1'b0,
      FULL    = 1'b1
   } fill_state_e;

   // Next fill level after one more sampled bit, clamped to the window size.
   function automatic logic [3:0] satFill(input logic [3:0] fill, input logic [3:0] limit);
      return (fill >= limit) ? limit : fill + 4'd1;
   endfunction

endpackage

// File: rtl/seq_detector_tick_sync.sv
// ----------------------------------------------------------------------------
// tick_sync
// Brings the slow divided square wave into the clk domain and turns each of
// its rising edges into a single-cycle sample strobe. Every flop of the
// synchronizer and the edge history resets to 1, so a wave that is already
// high when reset is released does not look like a fresh rising edge; the
// first strobe needs the wave to go low and then high again.
// Ports:
//   i_clk    in   system clock
//   i_rst    in   synchronous, active-high reset
//   i_async  in   asynchronous slow square wave
//   o_rise   out  registered one-cycle pulse per rising edge of i_async
// ----------------------------------------------------------------------------
module tick_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_rise;

   // Two-flop synchronizer, one flop of edge history and the registered edge
   // strobe. Reset clears the strobe, so a sample that was about to be
   // issued is dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_rise  <= 1'b0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_rise  <= r_sync2 & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/seq_detector.sv
// ----------------------------------------------------------------------------
// seq_detector
// Serial bit-pattern detector fed by the 1 Hz clock divider. The divided
// wave is treated purely as data: each of its rising edges (seen in the clk
// domain) samples the switch bit, and the detector flags when the last
// PAT_LEN samples equal PATTERN.
// Configuration macro:
//   SEQ_OVERLAP_EN - when defined, a match keeps the window so the following
//                    bits can complete an overlapping match; when undefined
//                    (default) a match clears the window and fill level.
// Ports:
//   i_clk           in   system clock
//   i_rst           in   synchronous, active-high reset
//   i_tick_clk      in   divided square wave, asynchronous
//   i_din           in   serial data bit (switch), asynchronous
//   o_match_pulse   out  one clk-cycle pulse per detected match
//   o_detected      out  high from a matching sample until the next sample
//   o_history       out  last HIST_W sampled bits, LSB newest
//   o_fill          out  valid bits in the window, 0..PAT_LEN
//   o_match_count   out  total matches, saturating at all-ones
// ----------------------------------------------------------------------------
module seq_detector #(
   parameter int                 PAT_LEN = seq_pkg::DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = seq_pkg::DEF_PATTERN[PAT_LEN-1:0],
   parameter int                 HIST_W  = seq_pkg::DEF_HIST_W,
   parameter int                 CNT_W   = seq_pkg::DEF_CNT_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tick_clk,
   input  logic              i_din,
   output logic              o_match_pulse,
   output logic              o_detected,
   output logic [HIST_W-1:0] o_history,
   output logic [3:0]        o_fill,
   output logic [CNT_W-1:0]  o_match_count
);

   import seq_pkg::*;

   localparam logic [3:0]       L_FULL_FILL = 4'(PAT_LEN);
   localparam logic [CNT_W-1:0] L_CNT_MAX   = '1;
`ifdef SEQ_OVERLAP_EN
   localparam bit L_OVERLAP = 1'b1;
`else
   localparam bit L_OVERLAP = 1'b0;
`endif

   logic w_sampleEn;

   logic r_dinSync1;
   logic r_dinSync2;

   fill_state_e r_state;
   fill_state_e w_stateNext;

   logic [PAT_LEN-1:0] r_window;
   logic [PAT_LEN-1:0] w_windowNext;
   logic [PAT_LEN-1:0] w_shiftWindow;
   logic [HIST_W-1:0]  r_history;
   logic [HIST_W-1:0]  w_historyNext;
   logic [3:0]         r_fill;
   logic [3:0]         w_fillNext;
   logic [3:0]         w_shiftFill;
   logic               r_detected;
   logic               w_detectedNext;
   logic               r_matchPulse;
   logic               w_matchPulseNext;
   logic [CNT_W-1:0]   r_matchCount;
   logic [CNT_W-1:0]   w_matchCountNext;
   logic               w_hit;

   tick_sync u_tickSync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_tick_clk),
      .o_rise  (w_sampleEn)
   );

   // The data bit only needs a plain two-flop synchronizer. It is given
   // several clk cycles to settle ahead of each tick edge, so its sync delay
   // never lines up badly with the strobe path.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dinSync1 <= 1'b0;
         r_dinSync2 <= 1'b0;
      end else begin
         r_dinSync1 <= i_din;
         r_dinSync2 <= r_dinSync1;
      end
   end

   // Fill-state register: FILLING until the window holds PAT_LEN bits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= FILLING;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and datapath logic. Everything holds between samples except
   // the match pulse, which is only ever high for the cycle after a sample.
   // Once FULL, the fill level is pinned at PAT_LEN. A match in the default
   // non-overlapping mode empties the window so the next match must be
   // built from entirely fresh bits.
   always_comb begin
      w_stateNext      = r_state;
      w_windowNext     = r_window;
      w_historyNext    = r_history;
      w_fillNext       = r_fill;
      w_detectedNext   = r_detected;
      w_matchPulseNext = 1'b0;
      w_matchCountNext = r_matchCount;

      w_shiftWindow = {r_window[PAT_LEN-2:0], r_dinSync2};
      w_shiftFill   = (r_state == FULL) ? L_FULL_FILL : satFill(r_fill, L_FULL_FILL);
      w_hit         = w_sampleEn && (w_shiftFill == L_FULL_FILL) && (w_shiftWindow == PATTERN);

      if (w_sampleEn) begin
         w_windowNext     = w_shiftWindow;
         w_historyNext    = {r_history[HIST_W-2:0], r_dinSync2};
         w_fillNext       = w_shiftFill;
         w_detectedNext   = w_hit;
         w_matchPulseNext = w_hit;
         w_stateNext      = (w_shiftFill == L_FULL_FILL) ? FULL : FILLING;

         if (w_hit && (r_matchCount != L_CNT_MAX)) begin
            w_matchCountNext = r_matchCount + CNT_W'(1);
         end

         if (w_hit && !L_OVERLAP) begin
            w_windowNext = '0;
            w_fillNext   = 4'd0;
            w_stateNext  = FILLING;
         end
      end
   end

   // Datapath registers. Reset discards any partial window and the count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_window     <= '0;
         r_history    <= '0;
         r_fill       <= 4'd0;
         r_detected   <= 1'b0;
         r_matchPulse <= 1'b0;
         r_matchCount <= '0;
      end else begin
         r_window     <= w_windowNext;
         r_history    <= w_historyNext;
         r_fill       <= w_fillNext;
         r_detected   <= w_detectedNext;
         r_matchPulse <= w_matchPulseNext;
         r_matchCount <= w_matchCountNext;
      end
   end

   assign o_match_pulse = r_matchPulse;
   assign o_detected    = r_detected;
   assign o_history     = r_history;
   assign o_fill        = r_fill;
   assign o_match_count = r_matchCount;

endmodule

// File: tb/tb_seq_detector.sv
// ----------------------------------------------------------------------------
// tb_seq_detector
// Drives the detector with a 20-clk tick wave and directed bit sequences.
// A queue-based model of the sampled bit stream predicts every output; a
// second instance with a 2-bit counter shares the stimulus to exercise
// counter saturation. Honours SEQ_OVERLAP_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_seq_detector;

   localparam int         PAT_LEN     = 4;
   localparam logic [3:0] PATTERN     = 4'b1011;
   localparam int         HIST_W      = 8;
   localparam int         CNT_W       = 8;
   localparam int         SMALL_CNT_W = 2;
`ifdef SEQ_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tickClk = 1'b0;
   logic din = 1'b0;

   logic              matchPulse;
   logic              detected;
   logic [HIST_W-1:0] history;
   logic [3:0]        fill;
   logic [CNT_W-1:0]  matchCount;

   logic                   smallPulse;
   logic                   smallDetected;
   logic [HIST_W-1:0]      smallHistory;
   logic [3:0]             smallFill;
   logic [SMALL_CNT_W-1:0] smallCount;

   int testsRun = 0;
   int testsFailed = 0;

   bit histQ[$];
   bit winQ[$];
   int mdlCount = 0;
   bit mdlDetected = 1'b0;
   int expPulse = 0;
   int sampleId = 0;
   bit settled = 1'b0;

   int lastId = -1;
   int pulseCnt = 0;
   int smallPulseCnt = 0;

   seq_detector #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .HIST_W  (HIST_W),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_tick_clk    (tickClk),
      .i_din         (din),
      .o_match_pulse (matchPulse),
      .o_detected    (detected),
      .o_history     (history),
      .o_fill        (fill),
      .o_match_count (matchCount)
   );

   seq_detector #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .HIST_W  (HIST_W),
      .CNT_W   (SMALL_CNT_W)
   ) dutSmall (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_tick_clk    (tickClk),
      .i_din         (din),
      .o_match_pulse (smallPulse),
      .o_detected    (smallDetected),
      .o_history     (smallHistory),
      .o_fill        (smallFill),
      .o_match_count (smallCount)
   );

   // 100 MHz system clock.
   always #5 clk = ~clk;

   // Hard time limit so a stuck run still ends with a report.
   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation time limit reached, %0d tests run, %0d failed", testsRun, testsFailed);
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Last HIST_W sampled bits since reset, newest in the LSB.
   function automatic logic [31:0] expHistory();
      logic [31:0] v;
      int start;
      v = 32'd0;
      start = (histQ.size() > HIST_W) ? histQ.size() - HIST_W : 0;
      for (int i = start; i < histQ.size(); i++) begin
         v = {v[30:0], histQ[i]};
      end
      return v;
   endfunction

   function automatic int satCount(input int c, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (c > lim) ? lim : c;
   endfunction

   // Model: one sampled bit enters the stream; decide whether the last
   // PAT_LEN bits of the current window spell the pattern.
   task automatic modelSample(input bit b);
      bit hit;
      logic [PAT_LEN-1:0] pat;
      pat = PATTERN;
      histQ.push_back(b);
      winQ.push_back(b);
      if (winQ.size() > PAT_LEN) void'(winQ.pop_front());
      hit = (winQ.size() == PAT_LEN);
      for (int i = 0; i < winQ.size(); i++) begin
         if (winQ[i] != pat[PAT_LEN-1-i]) hit = 1'b0;
      end
      mdlDetected = hit;
      expPulse = hit ? 1 : 0;
      if (hit) mdlCount++;
      if (hit && !OVERLAP) winQ.delete();
      sampleId++;
   endtask

   task automatic modelReset();
      histQ.delete();
      winQ.delete();
      mdlCount = 0;
      mdlDetected = 1'b0;
      expPulse = 0;
      sampleId++;
   endtask

   // Compare process: once the outputs of the latest sample have settled,
   // check them every cycle; match pulses are counted per sample.
   always @(negedge clk) begin
      if (sampleId != lastId) begin
         lastId = sampleId;
         pulseCnt = 0;
         smallPulseCnt = 0;
      end
      if (matchPulse === 1'b1) pulseCnt++;
      if (smallPulse === 1'b1) smallPulseCnt++;
      if (settled) begin
         checkOutput("history", 32'(history), expHistory());
         checkOutput("fill", 32'(fill), 32'(winQ.size()));
         checkOutput("detected", 32'(detected), 32'(mdlDetected));
         checkOutput("match_count", 32'(matchCount), 32'(satCount(mdlCount, CNT_W)));
         checkOutput("pulse_count", 32'(pulseCnt), 32'(expPulse));
         checkOutput("small_count", 32'(smallCount), 32'(satCount(mdlCount, SMALL_CNT_W)));
         checkOutput("small_pulse_count", 32'(smallPulseCnt), 32'(expPulse));
         checkOutput("small_fill", 32'(smallFill), 32'(winQ.size()));
         checkOutput("small_history", 32'(smallHistory), expHistory());
         checkOutput("small_detected", 32'(smallDetected), 32'(mdlDetected));
      end
   end

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // One slow period: 10 clk low (data set up at least 3 clk before the
   // edge), then 10 clk high. With noisy set, din toggles everywhere except
   // the window around the rising edge.
   task automatic applyStimulus(input bit b, input bit noisy);
      tickClk = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (noisy) din = ~din;
         else din = b;
         stepClk();
      end
      din = b;
      repeat (3) stepClk();
      tickClk = 1'b1;
      modelSample(b);
      settled = 1'b0;
      repeat (6) stepClk();
      settled = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (noisy) din = ~din;
         stepClk();
      end
   endtask

   task automatic sendBits(input logic [31:0] bits, input int n, input bit noisy);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(bits[i], noisy);
      end
   endtask

   task automatic resetDut();
      settled = 1'b0;
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      modelReset();
      settled = 1'b1;
   endtask

   // A tick edge arrives, and reset lands in the cycle the sample strobe is
   // due: the sample must never reach the window.
   task automatic dropSample(input bit b);
      tickClk = 1'b0;
      din = b;
      repeat (10) stepClk();
      tickClk = 1'b1;
      settled = 1'b0;
      repeat (3) stepClk();
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      modelReset();
      settled = 1'b1;
      repeat (6) stepClk();
   endtask

   task automatic checkZeros(input string tag);
      @(negedge clk);
      checkOutput({tag, "_pulse"}, 32'(matchPulse), 32'd0);
      checkOutput({tag, "_detected"}, 32'(detected), 32'd0);
      checkOutput({tag, "_history"}, 32'(history), 32'd0);
      checkOutput({tag, "_fill"}, 32'(fill), 32'd0);
      checkOutput({tag, "_count"}, 32'(matchCount), 32'd0);
   endtask

   initial begin
      int fillExp[5];
      int smallExp[5];
      logic [31:0] endFill;

      endFill = OVERLAP ? 32'd4 : 32'd0;

      rst = 1'b1;
      repeat (3) stepClk();
      rst = 1'b0;
      modelReset();
      settled = 1'b1;
      checkZeros("reset");

      // Single pattern.
      sendBits(32'b1011, 4, 1'b0);
      @(negedge clk);
      checkOutput("t1_count", 32'(matchCount), 32'd1);
      checkOutput("t1_hist", 32'(history[3:0]), 32'hB);
      checkOutput("t1_detected", 32'(detected), 32'd1);
      checkOutput("t1_fill", 32'(fill), endFill);

      // Overlap candidate.
      resetDut();
      sendBits(32'b1011011, 7, 1'b0);
      @(negedge clk);
      checkOutput("t2_count", 32'(matchCount), OVERLAP ? 32'd2 : 32'd1);
      checkOutput("t2_hist", 32'(history), 32'h5B);
      checkOutput("t2_detected", 32'(detected), OVERLAP ? 32'd1 : 32'd0);
      checkOutput("t2_fill", 32'(fill), OVERLAP ? 32'd4 : 32'd3);

      // Fill progression with a leading non-matching bit.
      resetDut();
      fillExp = '{1, 2, 3, 4, 0};
      fillExp[4] = int'(endFill);
      begin
         logic [4:0] t3Bits;
         t3Bits = 5'b01011;
         for (int i = 0; i < 5; i++) begin
            applyStimulus(t3Bits[4-i], 1'b0);
            @(negedge clk);
            checkOutput("t3_fill", 32'(fill), 32'(fillExp[i]));
         end
      end
      checkOutput("t3_count", 32'(matchCount), 32'd1);

      // Back-to-back patterns; the small counter saturates at 3.
      resetDut();
      smallExp = '{1, 2, 3, 3, 3};
      for (int p = 0; p < 5; p++) begin
         sendBits(32'b1011, 4, 1'b0);
         @(negedge clk);
         checkOutput("t4_small_count", 32'(smallCount), 32'(smallExp[p]));
         checkOutput("t4_count", 32'(matchCount), 32'(p + 1));
      end

      // Reset while the tick wave is high discards a partial 101.
      resetDut();
      sendBits(32'b101, 3, 1'b0);
      resetDut();
      checkZeros("t5_reset");
      repeat (12) stepClk();
      checkZeros("t5_idle");
      sendBits(32'b1011, 4, 1'b0);
      @(negedge clk);
      checkOutput("t5_count", 32'(matchCount), 32'd1);
      checkOutput("t5_hist", 32'(history), 32'h0B);

      // Reset colliding with a pending sample strobe.
      resetDut();
      sendBits(32'b101, 3, 1'b0);
      dropSample(1'b1);
      checkZeros("drop");
      sendBits(32'b1011, 4, 1'b0);
      @(negedge clk);
      checkOutput("drop_count", 32'(matchCount), 32'd1);
      checkOutput("drop_hist", 32'(history), 32'h0B);

      // Noisy data between tick edges: only edge values are recorded.
      resetDut();
      sendBits(32'b11010011, 8, 1'b1);
      @(negedge clk);
      checkOutput("t6_hist", 32'(history), 32'hD3);
      checkOutput("t6_count", 32'(matchCount), 32'd0);
      checkOutput("t6_fill", 32'(fill), 32'd4);

      settled = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
